// File: rtl/chess_pkg.sv
// Shared types and constants for the chess board renderer: geometry, piece codes, colours, arbiter states.
// Pure declarations, no logic, so there is no latency and no backpressure.
package chess_pkg;

  localparam int unsigned BOARD_X0     = 80;
  localparam int unsigned SQ_PX        = 60;
  localparam int unsigned BOARD_PX     = 8 * SQ_PX;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned SPRITE_WORDS = 3600;

  typedef enum logic [3:0] {
    EMPTY    = 4'd0,
    W_PAWN   = 4'd1,
    W_KNIGHT = 4'd2,
    W_BISHOP = 4'd3,
    W_ROOK   = 4'd4,
    W_QUEEN  = 4'd5,
    W_KING   = 4'd6,
    B_PAWN   = 4'd7,
    B_KNIGHT = 4'd8,
    B_BISHOP = 4'd9,
    B_ROOK   = 4'd10,
    B_QUEEN  = 4'd11,
    B_KING   = 4'd12
  } piece_e;

  localparam logic [11:0] LIGHT_RGB  = 12'hEDB;
  localparam logic [11:0] DARK_RGB   = 12'hA75;
  localparam logic [11:0] CURSOR_RGB = 12'h4C4;
  localparam logic [11:0] SELECT_RGB = 12'hCC3;
  localparam logic [11:0] BORDER_RGB = 12'h333;

  typedef enum logic [1:0] {
    ARB_RENDER  = 2'd0,
    ARB_IDLE_VB = 2'd1,
    ARB_WRITE   = 2'd2
  } arb_state_e;

  // Per-pixel flags carried alongside the sprite fetch.
  typedef struct packed {
    logic blank;
    logic in_board;
    logic dark;
    logic hl_cur;
    logic hl_sel;
    logic empty;
  } pix_meta_t;

  // Codes above the last real piece have no sprite and render as an empty square.
  function automatic logic piece_is_empty(input logic [3:0] code);
    return (code == 4'(EMPTY)) || (code > 4'(B_KING));
  endfunction

endpackage

// File: rtl/board_port_arbiter.sv
// Shares the single board-RAM port between the renderer and game-logic writes; write issues one cycle after grant.
// Requests stall (no ack, nothing lost) until vertical blank; at most one write every two cycles.
module board_port_arbiter
  import chess_pkg::*;
(
  input  logic       vga_clk_i,
  input  logic       rst_i,
  input  logic [9:0] draw_y_i,
  input  logic       upd_req_i,
  input  logic [5:0] upd_addr_i,
  input  logic [3:0] upd_data_i,
  input  logic [5:0] render_addr_i,
  output logic       upd_ack_o,
  output logic [5:0] board_addr_o,
  output logic       board_we_o,
  output logic [3:0] board_wdata_o
);

  arb_state_e state_q;
  logic       we_q;
  logic       ack_q;
  logic [5:0] waddr_q;
  logic [3:0] wdata_q;
  logic       force_render;

  // The last line of the frame is reserved so the renderer owns the port when line 0 starts.
  assign force_render = (draw_y_i == 10'(V_TOTAL - 1)) || (draw_y_i < 10'(V_ACTIVE));

  always_ff @(posedge vga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_RENDER;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      waddr_q <= 6'd0;
      wdata_q <= 4'd0;
    end else begin
      we_q  <= 1'b0;
      ack_q <= 1'b0;
      if (force_render) begin
        state_q <= ARB_RENDER;
      end else begin
        case (state_q)
          ARB_RENDER:  state_q <= ARB_IDLE_VB;
          ARB_IDLE_VB: begin
            if (upd_req_i) begin
              state_q <= ARB_WRITE;
              we_q    <= 1'b1;
              ack_q   <= 1'b1;
              waddr_q <= upd_addr_i;
              wdata_q <= upd_data_i;
            end
          end
          ARB_WRITE:   state_q <= ARB_IDLE_VB;
          default:     state_q <= ARB_RENDER;
        endcase
      end
    end
  end

  assign upd_ack_o     = ack_q;
  assign board_we_o    = we_q;
  assign board_wdata_o = wdata_q;
  assign board_addr_o  = rst_i ? 6'd0 : ((state_q == ARB_WRITE) ? waddr_q : render_addr_i);

endmodule

// File: rtl/board_render_scheduler.sv
// Per-pixel chess board renderer: square lookup, sprite fetch and colour compose; 4 cycles from DrawX/DrawY/blank to RGB.
// No backpressure on the pixel stream; board writes from game logic are deferred to vertical blank.
module board_render_scheduler
  import chess_pkg::*;
(
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic [5:0]  cursor_sq,
  input  logic [5:0]  select_sq,
  input  logic        select_valid,
  input  logic        upd_req,
  input  logic [5:0]  upd_addr,
  input  logic [3:0]  upd_data,
  output logic        upd_ack,
  output logic [5:0]  board_addr,
  output logic        board_we,
  output logic [3:0]  board_wdata,
  input  logic [3:0]  board_rdata,
  output logic [15:0] rom_addr,
  input  logic [3:0]  rom_q,
  input  logic [11:0] pal_rgb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  logic       in_board;
  logic [9:0] x_off;
  logic [2:0] col;
  logic [2:0] row;
  logic [5:0] px;
  logic [5:0] py;
  logic [5:0] sq;

  pix_meta_t  s1_meta_d, s1_meta_q;
  logic [5:0] s1_px_q, s1_py_q;
  pix_meta_t  s2_meta_d, s2_meta_q;
  logic [15:0] rom_addr_d, rom_addr_q;
  pix_meta_t  s3_meta_q;
  logic [11:0] rgb_d, rgb_q;

  // Square decode from the live pixel position; off-board pixels map to square 0.
  always_comb begin
    in_board = (DrawX >= 10'(BOARD_X0)) && (DrawX < 10'(BOARD_X0 + BOARD_PX)) &&
               (DrawY < 10'(BOARD_PX));
    x_off = 10'd0;
    col   = 3'd0;
    row   = 3'd0;
    px    = 6'd0;
    py    = 6'd0;
    if (in_board) begin
      x_off = DrawX - 10'(BOARD_X0);
      col   = 3'(x_off / 10'(SQ_PX));
      px    = 6'(x_off % 10'(SQ_PX));
      row   = 3'(DrawY / 10'(SQ_PX));
      py    = 6'(DrawY % 10'(SQ_PX));
    end
    sq = {row, col};
  end

  always_comb begin
    s1_meta_d          = '0;
    s1_meta_d.blank    = blank;
    s1_meta_d.in_board = in_board;
    s1_meta_d.dark     = row[0] ^ col[0];
    s1_meta_d.hl_cur   = in_board && (sq == cursor_sq);
    s1_meta_d.hl_sel   = in_board && select_valid && (sq == select_sq);
  end

  board_port_arbiter u_arb (
    .vga_clk_i     (vga_clk),
    .rst_i         (reset),
    .draw_y_i      (DrawY),
    .upd_req_i     (upd_req),
    .upd_addr_i    (upd_addr),
    .upd_data_i    (upd_data),
    .render_addr_i (sq),
    .upd_ack_o     (upd_ack),
    .board_addr_o  (board_addr),
    .board_we_o    (board_we),
    .board_wdata_o (board_wdata)
  );

  // The RAM samples the address on the same edge as S1, so board_rdata lines up with the S1 registers.
  always_comb begin
    s2_meta_d       = s1_meta_q;
    s2_meta_d.empty = !s1_meta_q.in_board || piece_is_empty(board_rdata);
    rom_addr_d      = 16'd0;
    if (!s2_meta_d.empty) begin
      rom_addr_d = ({12'd0, board_rdata} - 16'd1) * 16'(SPRITE_WORDS) +
                   16'(s1_py_q) * 16'(SQ_PX) + 16'(s1_px_q);
    end
  end

  // Palette index 0 is transparent and lets the square or highlight show through.
  always_comb begin
    rgb_d = s3_meta_q.dark ? DARK_RGB : LIGHT_RGB;
    if (!s3_meta_q.blank) begin
      rgb_d = 12'd0;
    end else if (!s3_meta_q.in_board) begin
      rgb_d = BORDER_RGB;
    end else if (!s3_meta_q.empty && (rom_q != 4'd0)) begin
      rgb_d = pal_rgb;
    end else if (s3_meta_q.hl_cur) begin
      rgb_d = CURSOR_RGB;
    end else if (s3_meta_q.hl_sel) begin
      rgb_d = SELECT_RGB;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      s1_meta_q  <= '0;
      s1_px_q    <= 6'd0;
      s1_py_q    <= 6'd0;
      s2_meta_q  <= '0;
      rom_addr_q <= 16'd0;
      s3_meta_q  <= '0;
      rgb_q      <= 12'd0;
    end else begin
      s1_meta_q  <= s1_meta_d;
      s1_px_q    <= px;
      s1_py_q    <= py;
      s2_meta_q  <= s2_meta_d;
      rom_addr_q <= rom_addr_d;
      s3_meta_q  <= s2_meta_q;
      rgb_q      <= rgb_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign red      = rgb_q[11:8];
  assign green    = rgb_q[7:4];
  assign blue     = rgb_q[3:0];

endmodule

// File: tb/tb_board_render_scheduler.sv
// Directed bench for board_render_scheduler with behavioural board RAM, sprite ROM and palette.
module tb_board_render_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [5:0]  cursor_sq, select_sq;
  logic        select_valid;
  logic        upd_req;
  logic [5:0]  upd_addr;
  logic [3:0]  upd_data;
  logic        upd_ack;
  logic [5:0]  board_addr;
  logic        board_we;
  logic [3:0]  board_wdata;
  logic [3:0]  board_rdata;
  logic [15:0] rom_addr;
  logic [3:0]  rom_q;
  logic [11:0] pal_rgb;
  logic [3:0]  red, green, blue;

  logic [3:0]  bram [64];
  logic        pre_clr, pre_we;
  logic [5:0]  pre_addr;
  logic [3:0]  pre_data;
  logic [3:0]  rom_val;

  int checks = 0;
  int errors = 0;
  int seen;

  localparam logic [11:0] LIGHT  = 12'hEDB;
  localparam logic [11:0] DARK   = 12'hA75;
  localparam logic [11:0] CURSOR = 12'h4C4;
  localparam logic [11:0] SELECT = 12'hCC3;
  localparam logic [11:0] BORDER = 12'h333;
  localparam logic [11:0] PAL5   = 12'h5AF;

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    if (pre_clr) begin
      for (int i = 0; i < 64; i++) bram[i] <= 4'd0;
    end else if (pre_we) begin
      bram[pre_addr] <= pre_data;
    end else if (board_we) begin
      bram[board_addr] <= board_wdata;
    end
    board_rdata <= bram[board_addr];
    rom_q       <= rom_val;
  end

  assign pal_rgb = {rom_q, ~rom_q, rom_q ^ 4'hA};

  board_render_scheduler dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .cursor_sq    (cursor_sq),
    .select_sq    (select_sq),
    .select_valid (select_valid),
    .upd_req      (upd_req),
    .upd_addr     (upd_addr),
    .upd_data     (upd_data),
    .upd_ack      (upd_ack),
    .board_addr   (board_addr),
    .board_we     (board_we),
    .board_wdata  (board_wdata),
    .board_rdata  (board_rdata),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .pal_rgb      (pal_rgb),
    .red          (red),
    .green        (green),
    .blue         (blue)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [3:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick(1);
    pre_we   = 1'b0;
  endtask

  task automatic count_grants(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (upd_ack || board_we) seen++;
    end
  endtask

  function automatic logic [15:0] rgb();
    return {4'd0, red, green, blue};
  endfunction

  initial begin
    reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
    cursor_sq = 6'd63; select_sq = 6'd62; select_valid = 1'b0;
    upd_req = 1'b0; upd_addr = 6'd0; upd_data = 4'd0;
    pre_clr = 1'b1; pre_we = 1'b0; pre_addr = 6'd0; pre_data = 4'd0; rom_val = 4'd0;
    tick(2);
    pre_clr = 1'b0;
    chk("reset_rgb", rgb(), 16'd0);
    chk("reset_ack", 16'(upd_ack), 16'd0);
    chk("reset_we", 16'(board_we), 16'd0);
    chk("reset_board_addr", 16'(board_addr), 16'd0);
    chk("reset_rom_addr", rom_addr, 16'd0);
    reset = 1'b0;

    DrawX = 10'd80; DrawY = 10'd0; blank = 1'b1;
    tick(4); chk("sq0_light", rgb(), 16'(LIGHT));
    DrawX = 10'd140;
    tick(4); chk("sq1_dark", rgb(), 16'(DARK));

    preload(6'd9, 4'd3);
    DrawX = 10'd150; DrawY = 10'd70; rom_val = 4'd5;
    tick(1); chk("sq9_board_addr", 16'(board_addr), 16'd9);
    tick(1); chk("sq9_rom_addr", rom_addr, 16'd7810);
    tick(2); chk("sq9_sprite", rgb(), 16'(PAL5));
    rom_val = 4'd0;
    tick(4); chk("sq9_transparent", rgb(), 16'(LIGHT));
    cursor_sq = 6'd9; select_sq = 6'd9; select_valid = 1'b1;
    tick(4); chk("cursor_over_select", rgb(), 16'(CURSOR));
    cursor_sq = 6'd10;
    tick(4); chk("select_hl", rgb(), 16'(SELECT));
    select_valid = 1'b0;
    tick(4); chk("select_invalid", rgb(), 16'(LIGHT));
    cursor_sq = 6'd9; rom_val = 4'd5;
    tick(4); chk("sprite_over_cursor", rgb(), 16'(PAL5));
    cursor_sq = 6'd63;

    preload(6'd9, 4'd13);
    tick(2); chk("code13_rom_addr", rom_addr, 16'd0);
    tick(2); chk("code13_empty", rgb(), 16'(LIGHT));
    DrawX = 10'd79;
    tick(4); chk("border_left", rgb(), 16'(BORDER));
    DrawX = 10'd560;
    tick(4); chk("border_right", rgb(), 16'(BORDER));
    DrawX = 10'd150; blank = 1'b0;
    tick(4); chk("blanked", rgb(), 16'd0);

    preload(6'd63, 4'd12);
    blank = 1'b1; DrawX = 10'd559; DrawY = 10'd479;
    tick(1); chk("sq63_board_addr", 16'(board_addr), 16'd63);
    tick(1); chk("max_rom_addr", rom_addr, 16'd43199);

    rom_val = 4'd0; DrawX = 10'd200; DrawY = 10'd100;
    upd_req = 1'b1; upd_addr = 6'd12; upd_data = 4'd6;
    seen = 0;
    count_grants(20);
    DrawY = 10'd479;
    count_grants(5);
    chk("no_grant_active", 16'(seen), 16'd0);
    DrawY = 10'd480;
    tick(1); chk("vb_first_we", 16'(board_we), 16'd0);
    tick(1);
    chk("wr1_ack", 16'(upd_ack), 16'd1);
    chk("wr1_we", 16'(board_we), 16'd1);
    chk("wr1_addr", 16'(board_addr), 16'd12);
    chk("wr1_data", 16'(board_wdata), 16'd6);
    upd_req = 1'b0;
    tick(1);
    chk("wr1_ack_drop", 16'(upd_ack), 16'd0);
    chk("wr1_we_drop", 16'(board_we), 16'd0);
    chk("wr1_ram", 16'(bram[12]), 16'd6);

    DrawX = 10'd330; DrawY = 10'd70; rom_val = 4'd5;
    tick(1); chk("sq12_board_addr", 16'(board_addr), 16'd12);
    tick(1); chk("sq12_rom_addr", rom_addr, 16'd18610);
    tick(2); chk("sq12_sprite", rgb(), 16'(PAL5));

    blank = 1'b0; DrawY = 10'd500; rom_val = 4'd0;
    tick(2);
    DrawY = 10'd524; upd_req = 1'b1; upd_addr = 6'd20; upd_data = 4'd2;
    seen = 0;
    count_grants(5);
    DrawY = 10'd0;
    count_grants(5);
    chk("no_grant_line524", 16'(seen), 16'd0);
    DrawY = 10'd480;
    tick(1); chk("vb2_first_we", 16'(board_we), 16'd0);
    tick(1);
    chk("wr2_ack", 16'(upd_ack), 16'd1);
    chk("wr2_addr", 16'(board_addr), 16'd20);
    chk("wr2_data", 16'(board_wdata), 16'd2);
    upd_addr = 6'd21; upd_data = 4'd3;
    tick(1); chk("b2b_gap_ack", 16'(upd_ack), 16'd0);
    tick(1);
    chk("wr3_ack", 16'(upd_ack), 16'd1);
    chk("wr3_addr", 16'(board_addr), 16'd21);
    chk("wr3_data", 16'(board_wdata), 16'd3);
    upd_req = 1'b0;
    tick(1);
    chk("wr3_we_drop", 16'(board_we), 16'd0);
    chk("wr2_ram", 16'(bram[20]), 16'd2);
    chk("wr3_ram", 16'(bram[21]), 16'd3);

    upd_req = 1'b1; upd_addr = 6'd5; upd_data = 4'd7;
    tick(1); chk("wr4_we", 16'(board_we), 16'd1);
    reset = 1'b1; upd_req = 1'b0;
    #1;
    chk("rst_mid_we", 16'(board_we), 16'd0);
    chk("rst_mid_ack", 16'(upd_ack), 16'd0);
    chk("rst_mid_addr", 16'(board_addr), 16'd0);
    chk("rst_mid_rgb", rgb(), 16'd0);
    DrawX = 10'd140; DrawY = 10'd0; blank = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("refill_board_addr", 16'(board_addr), 16'd1);
    chk("refill_rgb1", rgb(), 16'd0);
    tick(1); chk("refill_rgb2", rgb(), 16'd0);
    tick(1); chk("refill_rgb3", rgb(), 16'd0);
    tick(1); chk("refill_rgb4", rgb(), 16'(DARK));
    chk("rst_no_write", 16'(bram[5]), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
